// File: rtl/result_seg_encoder_if.sv
// Handshake and segment-word bundle between the result register, the encoder and the display serializer.
interface result_seg_encoder_if;
  logic        load;
  logic [31:0] value;
  logic        hex_mode;
  logic        busy;
  logic [63:0] PData;
  logic        start;

  modport master (output load, value, hex_mode, input busy, PData, start);
  modport slave  (input load, value, hex_mode, output busy, PData, start);
endinterface

// File: rtl/result_seg_encoder.sv
// Turns a 32-bit result into an active-low seven-segment word (signed decimal via
// bit-serial double dabble, or raw hex) and strobes it to the display serializer.
module result_seg_encoder #(
  parameter int unsigned START_WIDTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  result_seg_encoder_if.slave  bus
);

  localparam int unsigned VAL_W = 32;
  localparam int unsigned BCD_W = 40;
  localparam int unsigned PD_W  = 64;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned SW_W  = $clog2(START_WIDTH + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CONV   = 2'd1;
  localparam logic [1:0] S_ENCODE = 2'd2;
  localparam logic [1:0] S_STROBE = 2'd3;

  localparam logic [PD_W-1:0] PD_BLANK = {PD_W{1'b1}};
  localparam logic [PD_W-1:0] PD_ERROR = 64'hFFFFFF86_AFAFA3AF;
  localparam logic [7:0]      SEG_MINUS = 8'hBF;

  logic [1:0]       state_q, state_d;
  logic [VAL_W-1:0] mag_q, mag_d;
  logic [BCD_W-1:0] bcd_q, bcd_d, bcd_adj;
  logic             sign_q, sign_d;
  logic             hex_q, hex_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SW_W-1:0]  scnt_q, scnt_d;
  logic [PD_W-1:0]  pdata_q, pdata_d, pdata_enc;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic [2:0]       msd;
  logic             ovf;

  function automatic logic [7:0] seg_glyph(input logic [3:0] d);
    case (d)
      4'h0: seg_glyph = 8'hC0;  4'h1: seg_glyph = 8'hF9;
      4'h2: seg_glyph = 8'hA4;  4'h3: seg_glyph = 8'hB0;
      4'h4: seg_glyph = 8'h99;  4'h5: seg_glyph = 8'h92;
      4'h6: seg_glyph = 8'h82;  4'h7: seg_glyph = 8'hF8;
      4'h8: seg_glyph = 8'h80;  4'h9: seg_glyph = 8'h90;
      4'hA: seg_glyph = 8'h88;  4'hB: seg_glyph = 8'h83;
      4'hC: seg_glyph = 8'hC6;  4'hD: seg_glyph = 8'hA1;
      4'hE: seg_glyph = 8'h86;  default: seg_glyph = 8'h8E;
    endcase
  endfunction

  // Double-dabble correction: any BCD digit >= 5 gets +3 before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 10; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Display word from the finished conversion (or raw nibbles in hex mode).
  always_comb begin
    pdata_enc = PD_BLANK;
    msd       = 3'd0;
    ovf       = 1'b0;
    if (hex_q) begin
      for (int i = 0; i < 8; i++) pdata_enc[8*i +: 8] = seg_glyph(mag_q[4*i +: 4]);
    end else begin
      ovf = (bcd_q[39:32] != 8'd0) || (sign_q && (bcd_q[31:28] != 4'd0));
      for (int i = 0; i < 8; i++) begin
        if (bcd_q[4*i +: 4] != 4'd0) msd = 3'(i);
      end
      if (ovf) begin
        pdata_enc = PD_ERROR;
      end else begin
        for (int i = 0; i < 8; i++) begin
          if (3'(i) <= msd)                         pdata_enc[8*i +: 8] = seg_glyph(bcd_q[4*i +: 4]);
          else if (sign_q && (3'(i) == msd + 3'd1)) pdata_enc[8*i +: 8] = SEG_MINUS;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    sign_d  = sign_q;
    hex_d   = hex_q;
    cnt_d   = cnt_q;
    scnt_d  = scnt_q;
    pdata_d = pdata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.load) begin
          hex_d   = bus.hex_mode;
          sign_d  = bus.value[31] & ~bus.hex_mode;
          mag_d   = (bus.value[31] && !bus.hex_mode) ? -bus.value : bus.value;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = bus.hex_mode ? S_ENCODE : S_CONV;
        end
      end
      S_CONV: begin
        {bcd_d, mag_d} = {bcd_adj, mag_q} << 1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_ENCODE;
      end
      S_ENCODE: begin
        pdata_d = pdata_enc;
        scnt_d  = '0;
        state_d = S_STROBE;
      end
      default: begin
        if (scnt_q == SW_W'(START_WIDTH - 1)) state_d = S_IDLE;
        else                                   scnt_d  = scnt_q + 1'b1;
      end
    endcase
    busy_d  = (state_d != S_IDLE);
    start_d = (state_d == S_STROBE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mag_q   <= '0;
      bcd_q   <= '0;
      sign_q  <= 1'b0;
      hex_q   <= 1'b0;
      cnt_q   <= '0;
      scnt_q  <= '0;
      pdata_q <= PD_BLANK;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      sign_q  <= sign_d;
      hex_q   <= hex_d;
      cnt_q   <= cnt_d;
      scnt_q  <= scnt_d;
      pdata_q <= pdata_d;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.start = start_q;
  assign bus.PData = pdata_q;

endmodule

// File: tb/tb_result_seg_encoder.sv
// Directed bench for result_seg_encoder: latency, strobe width, glyph words, overflow and reset abort.
module tb_result_seg_encoder;

  localparam int unsigned SW = 4;
  localparam logic [63:0] BLANK = 64'hFFFFFFFF_FFFFFFFF;
  localparam logic [63:0] ERR   = 64'hFFFFFF86_AFAFA3AF;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [63:0] prev_pd;

  result_seg_encoder_if bus();

  result_seg_encoder #(.START_WIDTH(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Caller is positioned just after a negedge; load is sampled on the next posedge (cycle 0).
  task automatic run_conv(input string tag, input logic [31:0] v, input logic hx,
                          input logic [63:0] exp_pd, input int exp_rise, input bit inject);
    int   rise;
    int   width;
    int   rises;
    logic last_start;
    rise = -1; width = 0; rises = 0; last_start = 1'b0;
    bus.load = 1'b1; bus.value = v; bus.hex_mode = hx;
    @(posedge clk);
    for (int n = 1; n <= exp_rise + int'(SW); n++) begin
      @(negedge clk);
      bus.load = (inject && (n == 5 || n == 20));
      if (inject && n == 5) begin bus.value = 32'd777; bus.hex_mode = 1'b1; end
      if (n == 1) check({tag, " busy_c1"}, 64'(bus.busy), 64'd1);
      if (n == exp_rise - 1) check({tag, " pd_hold"}, bus.PData, prev_pd);
      if (n == exp_rise + int'(SW) - 1) check({tag, " busy_last"}, 64'(bus.busy), 64'd1);
      if (n == exp_rise + int'(SW)) check({tag, " busy_fall"}, 64'(bus.busy), 64'd0);
      if (bus.start) begin
        width++;
        if (!last_start) begin
          rises++;
          if (rise < 0) rise = n;
          check({tag, " pdata"}, bus.PData, exp_pd);
        end
      end
      last_start = bus.start;
    end
    bus.load = 1'b0;
    check({tag, " rise"}, 64'(rise), 64'(exp_rise));
    check({tag, " width"}, 64'(width), 64'(SW));
    if (inject) check({tag, " pulses"}, 64'(rises), 64'd1);
    prev_pd = exp_pd;
  endtask

  task automatic run_reset_abort();
    int starts;
    starts = 0;
    bus.load = 1'b1; bus.value = 32'd12345; bus.hex_mode = 1'b0;
    @(posedge clk);
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      bus.load = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("rst busy", 64'(bus.busy), 64'd0);
    check("rst start", 64'(bus.start), 64'd0);
    check("rst pdata", bus.PData, BLANK);
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.start) starts++;
    end
    check("rst no_start", 64'(starts), 64'd0);
    check("rst idle", 64'(bus.busy), 64'd0);
    prev_pd = BLANK;
  endtask

  initial begin
    checks = 0; failures = 0; prev_pd = BLANK;
    rst = 1'b0; bus.load = 1'b0; bus.value = '0; bus.hex_mode = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset start", 64'(bus.start), 64'd0);
    check("reset pdata", bus.PData, BLANK);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_conv("dec_0",      32'd0,          1'b0, 64'hFFFFFFFF_FFFFFFC0, 34, 1'b0);
    run_conv("dec_123",    32'd123,        1'b0, 64'hFFFFFFFF_FFF9A4B0, 34, 1'b0);
    run_conv("dec_m5",     -32'sd5,        1'b0, 64'hFFFFFFFF_FFFFBF92, 34, 1'b0);
    run_conv("dec_9x8",    32'd99999999,   1'b0, 64'h90909090_90909090, 34, 1'b0);
    run_conv("dec_m9x7",   -32'sd9999999,  1'b0, 64'hBF909090_90909090, 34, 1'b0);
    run_conv("dec_m1e7",   -32'sd10000000, 1'b0, ERR,                   34, 1'b0);
    run_conv("dec_1e8",    32'd100000000,  1'b0, ERR,                   34, 1'b0);
    run_conv("dec_min",    32'h8000_0000,  1'b0, ERR,                   34, 1'b0);
    run_conv("dec_1e7",    32'd10000000,   1'b0, 64'hF9C0C0C0_C0C0C0C0, 34, 1'b0);
    run_conv("dec_m1234567", -32'sd1234567, 1'b0, 64'hBFF9A4B0_999282F8, 34, 1'b0);
    run_conv("hex_dead",   32'hDEADBEEF,   1'b1, 64'hA18688A1_8386868E, 2,  1'b0);
    run_conv("hex_0",      32'h0,          1'b1, 64'hC0C0C0C0_C0C0C0C0, 2,  1'b0);
    run_conv("ign_42",     32'd42,         1'b0, 64'hFFFFFFFF_FFFF99A4, 34, 1'b1);
    run_reset_abort();
    run_conv("post_rst",   32'd7,          1'b0, 64'hFFFFFFFF_FFFFFFF8, 34, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
